// File: rtl/decode_pipe.sv
// Decode/register-read stage: register file, immediate extension, operand-2 select,
// load-use hazard detection and the output register toward execute.
// Optional macro DECODE_PIPE_BYPASS_EN forwards a same-cycle writeback to the read ports.
module decode_pipe #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned REG_AW   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic [REG_AW-1:0] rd_reg_1,
  input  logic [REG_AW-1:0] rd_reg_2,
  input  logic              use_rd_1,
  input  logic              use_rd_2,
  input  logic              oprnd_sel,
  input  logic [1:0]        sext_op,
  input  logic [REG_AW-1:0] dst_reg,
  input  logic              dst_wr_en,
  input  logic              is_load,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_wr_reg,
  input  logic [WIDTH-1:0]  wb_wr_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  rd_data_1,
  output logic [WIDTH-1:0]  rd_data_2,
  output logic [WIDTH-1:0]  oprnd_2,
  output logic [WIDTH-1:0]  sext_imm,
  output logic [REG_AW-1:0] out_wr_reg,
  output logic              out_wr_en,
  output logic              out_is_load,
  output logic [15:0]       stall_cnt,
  output logic              err
);

  localparam logic [REG_AW:0] NumRegsW = (REG_AW + 1)'(NUM_REGS);

  logic [WIDTH-1:0]  regs_q [NUM_REGS];
  logic              valid_q;
  logic [WIDTH-1:0]  rd1_q, rd2_q, op2_q, imm_q;
  logic [REG_AW-1:0] wr_reg_q;
  logic              wr_en_q, is_load_q;
  logic [15:0]       stall_cnt_q;
  logic              err_q;

  logic [WIDTH-1:0]  rs1_data, rs2_data, imm_ext;
  logic              rd1_ok, rd2_ok, wb_ok;
  logic              ld_stall, wb_stall, hazard, accept, err_set;
  logic              unused_instr;

  assign unused_instr = ^instr[15:11];

  assign rd1_ok = {1'b0, rd_reg_1} < NumRegsW;
  assign rd2_ok = {1'b0, rd_reg_2} < NumRegsW;
  assign wb_ok  = {1'b0, wb_wr_reg} < NumRegsW;

  // Out-of-range indices match no entry and read as zero.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_reg_1 == REG_AW'(i)) rs1_data = regs_q[i];
      if (rd_reg_2 == REG_AW'(i)) rs2_data = regs_q[i];
    end
`ifdef DECODE_PIPE_BYPASS_EN
    if (wb_wr_en && wb_ok && rd_reg_1 == wb_wr_reg) rs1_data = wb_wr_data;
    if (wb_wr_en && wb_ok && rd_reg_2 == wb_wr_reg) rs2_data = wb_wr_data;
`endif
  end

  always_comb begin
    imm_ext = '0;
    unique case (sext_op)
      2'b00:   imm_ext = {{(WIDTH - 5){instr[4]}}, instr[4:0]};
      2'b01:   imm_ext = {{(WIDTH - 8){instr[7]}}, instr[7:0]};
      2'b10:   imm_ext = {{(WIDTH - 11){instr[10]}}, instr[10:0]};
      default: imm_ext = {{(WIDTH - 5){1'b0}}, instr[4:0]};
    endcase
  end

  assign ld_stall = valid_q & is_load_q & wr_en_q &
                    ((use_rd_1 & (rd_reg_1 == wr_reg_q)) | (use_rd_2 & (rd_reg_2 == wr_reg_q)));

`ifdef DECODE_PIPE_BYPASS_EN
  assign wb_stall = 1'b0;
`else
  // Without forwarding, wait until the pending writeback is in the array.
  assign wb_stall = wb_wr_en & wb_ok &
                    ((use_rd_1 & (rd_reg_1 == wb_wr_reg)) | (use_rd_2 & (rd_reg_2 == wb_wr_reg)));
`endif

  assign hazard   = ld_stall | wb_stall;
  assign in_ready = rst & (~valid_q | out_ready) & ~hazard & ~flush;
  assign accept   = in_valid & in_ready;
  assign err_set  = (accept & ((use_rd_1 & ~rd1_ok) | (use_rd_2 & ~rd2_ok))) |
                    (wb_wr_en & ~wb_ok);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wb_wr_en && wb_wr_reg == REG_AW'(i)) regs_q[i] <= wb_wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      op2_q     <= '0;
      imm_q     <= '0;
      wr_reg_q  <= '0;
      wr_en_q   <= 1'b0;
      is_load_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      rd1_q     <= rs1_data;
      rd2_q     <= rs2_data;
      op2_q     <= oprnd_sel ? imm_ext : rs2_data;
      imm_q     <= imm_ext;
      wr_reg_q  <= dst_reg;
      wr_en_q   <= dst_wr_en;
      is_load_q <= is_load;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (in_valid && hazard && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign out_valid   = valid_q;
  assign rd_data_1   = rd1_q;
  assign rd_data_2   = rd2_q;
  assign oprnd_2     = op2_q;
  assign sext_imm    = imm_q;
  assign out_wr_reg  = wr_reg_q;
  assign out_wr_en   = wr_en_q;
  assign out_is_load = is_load_q;
  assign stall_cnt   = stall_cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed self-checking bench for decode_pipe, built with NUM_REGS=6 so the
// out-of-range read case is reachable.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] instr;
  logic [2:0]  rd_reg_1, rd_reg_2, dst_reg, wb_wr_reg, out_wr_reg;
  logic        use_rd_1, use_rd_2, oprnd_sel, dst_wr_en, is_load, wb_wr_en, flush;
  logic [1:0]  sext_op;
  logic [15:0] wb_wr_data;
  logic        out_valid, out_ready, out_wr_en, out_is_load, err;
  logic [15:0] rd_data_1, rd_data_2, oprnd_2, sext_imm, stall_cnt;

  int checks = 0;
  int failures = 0;

  decode_pipe #(.WIDTH(16), .NUM_REGS(6), .REG_AW(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rd_reg_1(rd_reg_1), .rd_reg_2(rd_reg_2), .use_rd_1(use_rd_1), .use_rd_2(use_rd_2),
    .oprnd_sel(oprnd_sel), .sext_op(sext_op), .dst_reg(dst_reg), .dst_wr_en(dst_wr_en),
    .is_load(is_load), .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg), .wb_wr_data(wb_wr_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .rd_data_1(rd_data_1),
    .rd_data_2(rd_data_2), .oprnd_2(oprnd_2), .sext_imm(sext_imm), .out_wr_reg(out_wr_reg),
    .out_wr_en(out_wr_en), .out_is_load(out_is_load), .stall_cnt(stall_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; registered outputs are sampled 1 ns after rising.
  task automatic drive_edge();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 0; instr = '0; rd_reg_1 = '0; rd_reg_2 = '0; use_rd_1 = 0;
    use_rd_2 = 0; oprnd_sel = 0; sext_op = '0; dst_reg = '0; dst_wr_en = 0; is_load = 0;
    wb_wr_en = 0; wb_wr_reg = '0; wb_wr_data = '0; flush = 0; out_ready = 1;

    tick(); tick();
    drive_edge(); #1;
    chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_rd_data_1", rd_data_1, 16'd0);

    // Writeback R3, then read it the next cycle.
    rst = 1'b1; wb_wr_en = 1; wb_wr_reg = 3'd3; wb_wr_data = 16'h1234;
    tick();
    drive_edge();
    wb_wr_en = 0; in_valid = 1; rd_reg_1 = 3'd3; use_rd_1 = 1; dst_reg = 3'd1; dst_wr_en = 1;
    #1 chk("rd_in_ready", {15'd0, in_ready}, 16'd1);
    tick();
    chk("rd_out_valid", {15'd0, out_valid}, 16'd1);
    chk("rd_r3", rd_data_1, 16'h1234);

    // Immediate extension.
    drive_edge();
    use_rd_1 = 0; instr = 16'h001F; sext_op = 2'b00; oprnd_sel = 1;
    tick();
    chk("imm5_sext", sext_imm, 16'hFFFF);
    chk("imm5_op2", oprnd_2, 16'hFFFF);
    drive_edge(); sext_op = 2'b11;
    tick();
    chk("imm5_zext", sext_imm, 16'h001F);
    drive_edge(); instr = 16'h0480; sext_op = 2'b10;
    tick();
    chk("disp11", sext_imm, 16'hFC80);
    drive_edge(); instr = 16'h0085; sext_op = 2'b01;
    tick();
    chk("imm8", sext_imm, 16'hFF85);
    drive_edge(); oprnd_sel = 0; rd_reg_2 = 3'd3; use_rd_2 = 1;
    tick();
    chk("op2_rs2", oprnd_2, 16'h1234);
    chk("stall_none_yet", stall_cnt, 16'd0);

    // Load into R2 followed by a dependent use.
    drive_edge();
    use_rd_2 = 0; is_load = 1; dst_wr_en = 1; dst_reg = 3'd2; instr = 16'h0000; sext_op = 2'b00;
    tick();
    chk("ld_out_is_load", {15'd0, out_is_load}, 16'd1);
    drive_edge();
    is_load = 0; dst_reg = 3'd4; rd_reg_1 = 3'd2; use_rd_1 = 1;
    #1 chk("ld_stall_ready", {15'd0, in_ready}, 16'd0);
    tick();
    chk("ld_bubble", {15'd0, out_valid}, 16'd0);
    chk("ld_stall_cnt", stall_cnt, 16'd1);
    drive_edge(); #1;
    chk("ld_after_ready", {15'd0, in_ready}, 16'd1);
    tick();
    chk("ld_dep_valid", {15'd0, out_valid}, 16'd1);
    chk("ld_dep_wr_reg", {13'd0, out_wr_reg}, 16'd4);
    chk("ld_stall_cnt_hold", stall_cnt, 16'd1);

    // Backpressure for three cycles, then flush.
    drive_edge();
    out_ready = 0; use_rd_1 = 0; dst_reg = 3'd5; instr = 16'h000A;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_in_ready", {15'd0, in_ready}, 16'd0);
      tick();
      chk("hold_valid", {15'd0, out_valid}, 16'd1);
      chk("hold_wr_reg", {13'd0, out_wr_reg}, 16'd4);
      chk("hold_imm", sext_imm, 16'h0000);
      drive_edge();
    end
    flush = 1;
    #1 chk("flush_in_ready", {15'd0, in_ready}, 16'd0);
    tick();
    chk("flush_valid", {15'd0, out_valid}, 16'd0);
    drive_edge(); flush = 0; in_valid = 0; out_ready = 1;
    tick();
    chk("flush_no_accept", {15'd0, out_valid}, 16'd0);
    chk("flush_imm_kept", sext_imm, 16'h0000);

    // Same-cycle writeback of R5 while reading it on port 2.
    drive_edge();
    in_valid = 1; dst_wr_en = 0; rd_reg_2 = 3'd5; use_rd_2 = 1;
    wb_wr_en = 1; wb_wr_reg = 3'd5; wb_wr_data = 16'hBEEF;
`ifdef DECODE_PIPE_BYPASS_EN
    #1 chk("byp_in_ready", {15'd0, in_ready}, 16'd1);
    tick();
    chk("byp_valid", {15'd0, out_valid}, 16'd1);
    chk("byp_rd2", rd_data_2, 16'hBEEF);
    chk("byp_stall_cnt", stall_cnt, 16'd1);
`else
    #1 chk("wb_stall_ready", {15'd0, in_ready}, 16'd0);
    tick();
    chk("wb_stall_bubble", {15'd0, out_valid}, 16'd0);
    chk("wb_stall_cnt", stall_cnt, 16'd2);
    drive_edge(); wb_wr_en = 0;
    #1 chk("wb_after_ready", {15'd0, in_ready}, 16'd1);
    tick();
    chk("wb_valid", {15'd0, out_valid}, 16'd1);
    chk("wb_rd2", rd_data_2, 16'hBEEF);
`endif

    // Out-of-range read with NUM_REGS=6.
    drive_edge();
    wb_wr_en = 0; use_rd_2 = 0; rd_reg_1 = 3'd7; use_rd_1 = 1;
    #1 chk("err_before", {15'd0, err}, 16'd0);
    tick();
    chk("oor_valid", {15'd0, out_valid}, 16'd1);
    chk("oor_rd1", rd_data_1, 16'd0);
    chk("oor_err", {15'd0, err}, 16'd1);
    drive_edge(); in_valid = 0; use_rd_1 = 0;
    tick(); tick();
    chk("err_sticky", {15'd0, err}, 16'd1);

    // Reset clears state, including the register file.
    drive_edge(); rst = 0;
    tick();
    chk("rst2_err", {15'd0, err}, 16'd0);
    chk("rst2_stall_cnt", stall_cnt, 16'd0);
    chk("rst2_valid", {15'd0, out_valid}, 16'd0);
    drive_edge(); rst = 1; in_valid = 1; rd_reg_1 = 3'd3; use_rd_1 = 1;
    tick();
    chk("rst2_r3_cleared", rd_data_1, 16'd0);
    drive_edge(); in_valid = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
